imem_fetch_ctrl: RTL

Fetch-stage controller that sequences the synchronous-read instruction memory: 128 words, word-indexed, 1-cycle read latency, no enable.
- Owns the PC and issues word addresses to the memory.
- Absorbs the read latency with an in-flight tag and a 1-entry skid buffer.
- Presents instructions to decode with a valid/stall handshake.
- Shares the memory read port with a debug/loader read requester.

---
 rtl/imem_fetch_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller for a 1-cycle synchronous-read instruction memory, with a shared debug read port.
// Build option: define FETCH_PERF_EN to add the consumed-instruction and stalled-cycle counters.
module imem_fetch_ctrl #(
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:0]       mem_addr,
    input  logic [31:0]       mem_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       instr,
    output logic [31:0]       pc_out,
    output logic              instr_valid,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic [31:0]       dbg_data,
    output logic              dbg_valid,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
);

    localparam logic [31:0] WRAP_MASK = 32'(DEPTH * 4 - 1);

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        DBG
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;
    logic        tag_vld_p1;
    logic [31:0] tag_pc_p1;
    logic        out_vld_p2;
    logic [31:0] out_instr_p2;
    logic [31:0] out_pc_p2;
    logic        skid_vld_p2;
    logic [31:0] skid_instr_p2;
    logic [31:0] skid_pc_p2;
    logic [31:0] dbg_hold;

    logic [31:0] redir_pc;
    logic        issue;
    logic        ret_vld;
    logic        consume;
    logic        skid_fill;
    logic        skid_drain;

    // Only the memory address wraps; the architectural PC keeps all 32 bits.
    function automatic logic [31:0] word_index(input logic [31:0] byte_pc);
        return (byte_pc & WRAP_MASK) >> 2;
    endfunction

    assign redir_pc   = redirect_pc & ~32'd3;
    assign ret_vld    = tag_vld_p1 && (state != DBG);
    assign consume    = out_vld_p2 && !stall;
    assign skid_fill  = ret_vld && out_vld_p2 && stall;
    assign skid_drain = skid_vld_p2 && consume;

    // Issue stage: one memory read slot per cycle, redirect > debug > fetch.
    always_comb begin
        state_nxt = RUN;
        dbg_gnt   = 1'b0;
        issue     = 1'b0;
        mem_addr  = word_index(pc);
        if (redirect) begin
            mem_addr = word_index(redir_pc);
        end else if (dbg_req) begin
            dbg_gnt   = 1'b1;
            mem_addr  = {{(32 - ADDR_W){1'b0}}, dbg_addr};
            state_nxt = DBG;
        end else begin
            issue = (state != HOLD) && !skid_vld_p2 && !(stall && out_vld_p2);
            if ((skid_vld_p2 && !skid_drain) || skid_fill) begin
                state_nxt = HOLD;
            end
        end
        if (!rst_n) begin
            mem_addr = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // p1 in-flight tag -> p2 output register, with the skid catching returns under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            tag_vld_p1    <= 1'b0;
            tag_pc_p1     <= '0;
            out_vld_p2    <= 1'b0;
            out_instr_p2  <= '0;
            out_pc_p2     <= '0;
            skid_vld_p2   <= 1'b0;
            skid_instr_p2 <= '0;
            skid_pc_p2    <= '0;
        end else if (redirect) begin
            pc          <= redir_pc + 32'd4;
            tag_vld_p1  <= 1'b1;
            tag_pc_p1   <= redir_pc;
            out_vld_p2  <= 1'b0;
            skid_vld_p2 <= 1'b0;
        end else begin
            tag_vld_p1 <= issue;
            if (issue) begin
                tag_pc_p1 <= pc;
                pc        <= pc + 32'd4;
            end
            if (skid_drain) begin
                out_instr_p2 <= skid_instr_p2;
                out_pc_p2    <= skid_pc_p2;
                skid_vld_p2  <= 1'b0;
            end else if (ret_vld && (consume || !out_vld_p2)) begin
                out_instr_p2 <= mem_data;
                out_pc_p2    <= tag_pc_p1;
                out_vld_p2   <= 1'b1;
            end else if (consume) begin
                out_vld_p2 <= 1'b0;
            end
            if (skid_fill) begin
                skid_instr_p2 <= mem_data;
                skid_pc_p2    <= tag_pc_p1;
                skid_vld_p2   <= 1'b1;
            end
        end
    end

    assign instr       = out_instr_p2;
    assign pc_out      = out_pc_p2;
    assign instr_valid = out_vld_p2;

    // Debug return is the memory output in the cycle after a grant; the last value is held after.
    assign dbg_valid = (state == DBG);
    assign dbg_data  = dbg_valid ? mem_data : dbg_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_hold <= '0;
        end else if (dbg_valid) begin
            dbg_hold <= mem_data;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (consume) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (out_vld_p2 && stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule
